// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-read-port register file with write tracking
//
// Holds l = 2**s registers of n bits. One write port commits on the rising
// clock edge when both gwe and wen are high. R read ports (1..4) return their
// selected register combinationally with no handshake. A per-register
// "written" bit and a distinct-write counter record which registers have been
// committed since reset.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   -> a read port whose select matches this cycle's committing write
//                returns wdata in the same cycle (write-to-read bypass).
//   undefined -> the read returns the pre-write value; the new value appears
//                from the next cycle on.
//
// Ports:
//   clk      in   1      single clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   gwe      in   1      global write enable; 0 freezes all state
//   wen      in   1      write request for this cycle
//   wsel     in   s      register to write
//   wdata    in   n      write data
//   rsel     in   R*s    packed read selects, port k at [k*s +: s]
//   rdata    out  R*n    packed read data,    port k at [k*n +: n]
//   written  out  l      bit i set once register i has been committed
//   wcount   out  s+1    number of distinct registers committed since reset
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int s = 3,
    parameter int n = 16,
    parameter int R = 2     // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gwe,
    input  logic                  wen,
    input  logic [s-1:0]          wsel,
    input  logic [n-1:0]          wdata,
    input  logic [R*s-1:0]        rsel,
    output logic [R*n-1:0]        rdata,
    output logic [(2**s)-1:0]     written,
    output logic [s:0]            wcount
);

    localparam int         L         = 2**s;
    localparam logic [s:0] CNT_MAX   = (s+1)'(L);
    localparam logic [s:0] CNT_ONE   = (s+1)'(1);

    logic [n-1:0] regs_q [L];
    logic [n-1:0] regs_d [L];
    logic [L-1:0] written_q, written_d;
    logic [s:0]   wcount_q,  wcount_d;
    logic         commit;

    // A commit needs both enables; either one low freezes every register.
    assign commit = gwe & wen;

    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        wcount_d  = wcount_q;
        if (commit) begin
            regs_d[wsel]    = wdata;
            written_d[wsel] = 1'b1;
            // Only a first write to a register counts; the saturation guard
            // keeps the counter at l even though it cannot logically exceed it.
            if (!written_q[wsel] && (wcount_q != CNT_MAX)) begin
                wcount_d = wcount_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                regs_q[i] <= '0;
            end
            written_q <= '0;
            wcount_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            written_q <= written_d;
            wcount_q  <= wcount_d;
        end
    end

    // Read ports: purely combinational, independent of each other.
    for (genvar k = 0; k < R; k++) begin : g_rd
        logic [s-1:0] sel_k;
        logic [n-1:0] val_k;

        assign sel_k = rsel[k*s +: s];

        always_comb begin
            val_k = regs_q[sel_k];
`ifdef REGFILE_BYPASS_EN
            if (commit && (sel_k == wsel)) begin
                val_k = wdata;
            end
`endif
            // While reset is held the output is forced to zero, which also
            // masks the bypass path.
            if (!rst_n) begin
                val_k = '0;
            end
        end

        assign rdata[k*n +: n] = val_k;
    end

    assign written = written_q;
    assign wcount  = wcount_q;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
- REQ-001 SHALL have parameter s, default 3: register-select width; register count l = 2**s.
- REQ-002 SHALL have parameter n, default 16: data width per register.
- REQ-003 SHALL have parameter R, default 2: number of read ports, legal range 1..4.
- REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
- REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port gwe, input, 1: global write enable; when 0, no state changes.
- REQ-007 SHALL have port wen, input, 1: write request for this cycle.
- REQ-008 SHALL have port wsel, input, s: register to write.
- REQ-009 SHALL have port wdata, input, n: write data.
- REQ-010 SHALL have port rsel, input, R*s: packed read selects; bits [s-1:0] belong to port 0, port k at [k*s+s-1:k*s].
- REQ-011 SHALL have port rdata, output, R*n: packed read data; port k at [k*n+n-1:k*n].
- REQ-012 SHALL have port written, output, l: bit i = register i written since reset.
- REQ-013 SHALL have port wcount, output, s+1: number of distinct registers written since reset.

Function
- REQ-014 SHALL hold l registers of n bits each.
- REQ-015 SHALL commit wdata into register wsel at a rising clk only when gwe=1 and wen=1.
- REQ-016 SHALL leave every register unchanged when gwe=0 or wen=0, including when wen=1 and gwe=0.
- REQ-017 SHALL return register rsel[k] on rdata[k] combinationally, with zero-cycle read latency and no read handshake.
- REQ-018 SHALL let all R ports read any register, including the same register, in the same cycle with no interaction.
- REQ-019 SHALL set written[wsel] to 1 at the committing edge; the bit stays set until reset.
- REQ-020 SHALL increment wcount by 1 only when a commit targets a register whose written bit was 0.
- REQ-021 SHALL saturate wcount at l; rewriting any register never changes it.
- REQ-022 SHALL make register 0 an ordinary register with no hardwired zero.
- REQ-023 SHALL keep rdata a pure function of current state and inputs, with no internal pipeline state.

Reset
- REQ-024 SHALL on rst_n=0, regardless of clk, clear all registers to 0, written to 0 and wcount to 0.
- REQ-025 SHALL give rdata=0 on every port while rst_n=0, with bypass ignored.
- REQ-026 SHALL discard a write whose edge coincides with rst_n=0.
- REQ-027 SHALL accept the first write at the first rising edge after rst_n deasserts.

Configuration
- REQ-028 SHALL use macro REGFILE_BYPASS_EN to control write-to-read bypass.
- REQ-029 SHALL, with REGFILE_BYPASS_EN defined, drive rdata[k]=wdata when gwe=1, wen=1 and rsel[k]==wsel in the same cycle, so a read sees this cycle's write.
- REQ-030 SHALL, without REGFILE_BYPASS_EN defined, return the pre-write register value in that cycle and the new value from the next cycle.

Verification (defaults s=3, n=16, R=2)
- REQ-031 SHALL cover: reset, then read all 8 registers on both ports -> all 0; written=8'h00, wcount=0.
- REQ-032 SHALL cover: write R3=16'hBEEF (gwe=1, wen=1), next cycle rsel={3,3} -> both ports 16'hBEEF; written=8'h08, wcount=1.
- REQ-033 SHALL cover: gwe=0, wen=1, wsel=5, wdata=16'h1234 -> R5 still 0; written[5]=0; wcount unchanged.
- REQ-034 SHALL cover: same-cycle write R2=16'hA5A5 with rsel port0=2 -> 16'hA5A5 with bypass defined, old value 0 without; both report 16'hA5A5 next cycle.
- REQ-035 SHALL cover: write all 8 registers, then rewrite R0 -> wcount=8 saturated, written=8'hFF.
- REQ-036 SHALL cover: assert rst_n low mid-cycle while a write is pending -> rdata=0 immediately, written=0, write lost.
